// File: rtl/fifo_rd_stage.sv
// fifo_rd_stage: read-side output stage of the asynchronous FIFO.
// Issues rd_en to the read-pointer handler, captures synchronous-read memory
// data one cycle later and presents it as a first-word-fall-through
// valid/ready stream backed by a 2-entry buffer.
// Optional feature macro: FIFO_RD_STALL_CNT_EN adds the saturating stall_cnt port.
module fifo_rd_stage #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  rclk,
    input  logic                  rrstn,
    input  logic                  empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [1:0]            occupancy
`ifdef FIFO_RD_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int unsigned LVL_W   = 3;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        ST_ZERO = 2'd0,
        ST_ONE  = 2'd1,
        ST_TWO  = 2'd2
    } occ_e;

    occ_e                  state;
    occ_e                  state_nxt;
    logic                  inflight;
    logic                  pop;
    logic                  accept;
    logic [LVL_W-1:0]      level;
    logic [DATA_WIDTH-1:0] entry1;
    logic [DATA_WIDTH-1:0] entry0_nxt;
    logic [DATA_WIDTH-1:0] entry1_nxt;

    assign pop       = dout_valid && dout_ready;
    assign level     = LVL_W'(state) + LVL_W'(inflight);
    assign occupancy = state;

    // Read request: only when data exists and buffer + in-flight stays within 2 after this pop
    always_comb begin
        rd_en = 1'b0;
        if (rrstn && !empty && (level < (LVL_W'(2) + LVL_W'(pop)))) begin
            rd_en = 1'b1;
        end
    end

    assign accept = rd_en && !empty;

    // Occupancy state register
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            state <= ST_ZERO;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy next-state from capture (inflight) and pop
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ZERO: begin
                if (inflight) state_nxt = ST_ONE;
            end
            ST_ONE: begin
                if (inflight && !pop)      state_nxt = ST_TWO;
                else if (!inflight && pop) state_nxt = ST_ZERO;
            end
            ST_TWO: begin
                if (pop && !inflight) state_nxt = ST_ONE;
            end
            default: state_nxt = ST_ZERO;
        endcase
    end

    // Buffer next values: shift on pop, captured word into the lowest free entry
    always_comb begin
        entry0_nxt = dout;
        entry1_nxt = entry1;
        case (state)
            ST_ZERO: begin
                if (inflight) entry0_nxt = fifo_rdata;
            end
            ST_ONE: begin
                if (inflight && pop)  entry0_nxt = fifo_rdata;
                if (inflight && !pop) entry1_nxt = fifo_rdata;
            end
            ST_TWO: begin
                if (pop) begin
                    entry0_nxt = entry1;
                    if (inflight) entry1_nxt = fifo_rdata;
                end
            end
            default: begin
                entry0_nxt = dout;
                entry1_nxt = entry1;
            end
        endcase
    end

    // Buffer entries, registered valid and in-flight marker
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            dout       <= '0;
            entry1     <= '0;
            dout_valid <= 1'b0;
            inflight   <= 1'b0;
        end else begin
            dout       <= entry0_nxt;
            entry1     <= entry1_nxt;
            dout_valid <= (state_nxt != ST_ZERO);
            inflight   <= accept;
        end
    end

`ifdef FIFO_RD_STALL_CNT_EN
    // Saturating count of cycles the consumer holds off a valid word
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            stall_cnt <= '0;
        end else if (dout_valid && !dout_ready && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end
`endif

endmodule

// File: doc/fifo_rd_stage.md
# fifo_rd_stage

Read-side output stage of the asynchronous FIFO. It runs in the read clock domain between the read-pointer handler and the FIFO consumer. It issues `rd_en` to the read-pointer handler, captures the synchronous-read memory data one cycle later, and presents it as a first-word-fall-through valid/ready stream. A 2-entry buffer sustains one word per cycle under continuous `dout_ready`.

## Interface
- `DATA_WIDTH`, 8, FIFO word width.
- `rclk`  in  1  read-domain clock.
- `rrstn`  in  1  asynchronous active-low reset; release is synchronous to `rclk`.
- `empty`  in  1  registered empty flag from the read-pointer handler.
- `rd_en`  out  1  read request to the read-pointer handler and the memory read port.
- `fifo_rdata`  in  DATA_WIDTH  memory read data, valid the cycle after an accepted read.
- `dout`  out  DATA_WIDTH  head word of the stream.
- `dout_valid`  out  1  `dout` holds a valid word.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `occupancy`  out  2  words held in the buffer, 0..2.
- `stall_cnt`  out  16  present only with `FIFO_RD_STALL_CNT_EN`.

## Operation
- Accepted read: `rd_en && !empty` in cycle N. `fifo_rdata` carries that word in cycle N+1.
- `inflight` flag: registered copy of (`rd_en && !empty`). It marks that `fifo_rdata` must be captured this cycle.
- `pop` = `dout_valid && dout_ready`.
- `rd_en` = `!empty && (occupancy + inflight - pop < 2)`. It is combinational and depends on `dout_ready` in the same cycle.
- `rd_en` is never asserted while `empty`=1. Reads are never issued when the buffer plus in-flight word would exceed 2 entries.
- The buffer is a 2-entry FIFO. Entry 0 is the head and drives `dout`. `dout_valid` = (`occupancy` != 0).
- State machine on `occupancy`, with `inflight` written as i and `pop` written as p:
  - ZERO: i → ONE.
  - ONE: i&!p → TWO; !i&p → ZERO; i&p → ONE, with entry 0 loaded from `fifo_rdata`; otherwise hold.
  - TWO: p&!i → ONE, with entry 1 shifted to entry 0; p&i → TWO, with the shift and `fifo_rdata` written to entry 1; otherwise hold.
  - TWO&i&!p cannot occur by construction of `rd_en`. Bench assertion: `occupancy`+`inflight` ≤ 2 at every edge.
- A captured word enters the lowest free entry after any pop shift. Word order is strictly preserved.
- `dout` is stable while `dout_valid && !dout_ready`. The consumer may rely on valid/ready hold semantics.
- Reset mid-operation: `inflight` is cleared and the buffer is emptied. A word in flight from the memory is discarded. Ownership of that word is the read-pointer handler's concern, since it is reset on the same `rrstn`.

## Timing
- Reset values: `rd_en`=0 (forced while `rrstn`=0), `dout_valid`=0, `dout`=0, `occupancy`=0, `inflight`=0, `stall_cnt`=0.
- Latency: `empty` falls in cycle N, so `rd_en`=1 in N, capture at the end of N+1, and `dout_valid`=1 in N+2.
- Throughput: 1 word/cycle with `dout_ready` held high and `empty` low. In steady state `occupancy`=1 and `inflight`=1.
- Back-pressure: with `dout_ready`=0 from a full stream, `occupancy` reaches 2 and `rd_en` drops in the same cycle that the sum reaches 2.
- All outputs except `rd_en` are registered.

## Configuration
- `FIFO_RD_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - The counter increments every cycle `dout_valid && !dout_ready` and saturates at 16'hFFFF.
  - Reset value 0; cleared only by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then idle with `empty`=1 → `rd_en`=0, `dout_valid`=0, `occupancy`=0 for 20 cycles.
- Write 0xA5 upstream. `empty` falls in cycle N and returns to 1 after one read → `rd_en` high only in N, `dout`=0xA5 and `dout_valid`=1 from N+2 until popped, then `occupancy`=0.
- Stream 0x00..0x0F with `dout_ready`=1 constantly → 16 consecutive pop cycles in order, `rd_en` never high while `empty`=1.
- Same stream with `dout_ready`=0 for cycles 5..12 → `occupancy` holds at 2, `rd_en`=0 throughout, `dout` stable, no loss or reorder after release.
- Assert `rrstn`=0 with `occupancy`=2 and `inflight`=1 → all outputs reach reset values immediately; after release the first `dout` is the next word supplied by the handler.
- With `FIFO_RD_STALL_CNT_EN`: hold `dout_valid`=1 and `dout_ready`=0 for 70000 cycles → `stall_cnt`=16'hFFFF and stays there.
